// File: rtl/barrett_reduce_58_pkg.sv
// Shared widths, latency and stage record for the 58-bit Barrett reduction pipeline.
package barrett_reduce_58_pkg;

  localparam int unsigned P_W         = 58;
  localparam int unsigned Q_W         = 34;
  localparam int unsigned MU_W        = 36;
  localparam int unsigned TAG_W       = 8;
  localparam int unsigned BARRETT_LAT = 6;

  localparam int unsigned T_W    = P_W - (Q_W - 1);   // 25-bit quotient estimate input
  localparam int unsigned PP_W   = T_W + MU_W / 2;    // 43-bit partial product
  localparam int unsigned PROD_W = T_W + MU_W;        // 61-bit t*mu
  localparam int unsigned QE_W   = PROD_W - (Q_W + 1); // 26-bit quotient estimate
  localparam int unsigned R_W    = Q_W + 2;           // 36-bit remainder arithmetic

  typedef struct packed {
    logic             valid;
    logic [P_W-1:0]   p;
    logic [TAG_W-1:0] tag;
  } stage_t;

endpackage

// File: rtl/barrett_reduce_58_if.sv
// Config, input and output streams of the Barrett reducer bundled as one interface.
interface barrett_reduce_58_if;
  import barrett_reduce_58_pkg::*;

  logic             cfg_we;
  logic [Q_W-1:0]   cfg_q;
  logic [MU_W-1:0]  cfg_mu;
  logic             cfg_err;
  logic             in_valid;
  logic             in_ready;
  logic [P_W-1:0]   in_p;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [Q_W-1:0]   out_r;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output cfg_we, cfg_q, cfg_mu, in_valid, in_p, in_tag, out_ready,
    input  cfg_err, in_ready, out_valid, out_r, out_tag
  );

  modport slave (
    input  cfg_we, cfg_q, cfg_mu, in_valid, in_p, in_tag, out_ready,
    output cfg_err, in_ready, out_valid, out_r, out_tag
  );

endinterface

// File: rtl/barrett_reduce_58_cond_sub.sv
// Final Barrett correction: subtract q up to twice so the result lands in [0, q).
module barrett_reduce_58_cond_sub
  import barrett_reduce_58_pkg::*;
(
  input  logic [R_W-1:0] r0,
  input  logic [Q_W-1:0] q,
  output logic [Q_W-1:0] r
);

  logic [R_W-1:0] q_ext;
  logic [R_W-1:0] r1;
  logic [R_W-1:0] r2;
  logic           unused_hi;

  always_comb begin
    q_ext     = R_W'(q);
    r1        = (r0 >= q_ext) ? r0 - q_ext : r0;
    r2        = (r1 >= q_ext) ? r1 - q_ext : r1;
    r         = r2[Q_W-1:0];
    unused_hi = ^r2[R_W-1:Q_W];
  end

endmodule

// File: rtl/barrett_reduce_58.sv
// Six-stage pipelined Barrett reduction p mod q with valid/ready backpressure and tag passthrough.
module barrett_reduce_58 (
  input logic               clk,
  input logic               rst,
  barrett_reduce_58_if.slave bus
);
  import barrett_reduce_58_pkg::*;

  localparam int unsigned MuLoW = MU_W / 2;

  stage_t            s1_q, s2_q, s3_q, s4_q;
  logic [PP_W-1:0]   pl_q, ph_q, pl_d, ph_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [R_W-1:0]    qeq_q, qeq_d, r0_q, r0_d;
  logic              v5_q;
  logic [TAG_W-1:0]  tag5_q;
  logic              out_valid_q;
  logic [Q_W-1:0]    out_r_q, r_d;
  logic [TAG_W-1:0]  out_tag_q;
  logic [Q_W-1:0]    q_q;
  logic [MU_W-1:0]   mu_q;
  logic              cfg_err_q;
  logic [T_W-1:0]    t;
  logic [QE_W-1:0]   qe;
  logic              adv;
  logic              empty;
  logic              unused_bits;

  always_comb begin
    adv   = !out_valid_q || bus.out_ready;
    empty = !(s1_q.valid || s2_q.valid || s3_q.valid || s4_q.valid || v5_q || out_valid_q);
    // t*mu split into two 25x18 partials, recombined one stage later
    t      = s1_q.p[P_W-1:Q_W-1];
    pl_d   = PP_W'(t) * PP_W'(mu_q[MuLoW-1:0]);
    ph_d   = PP_W'(t) * PP_W'(mu_q[MU_W-1:MuLoW]);
    prod_d = PROD_W'(pl_q) + (PROD_W'(ph_q) << MuLoW);
    // Only the low 36 bits of qe*q matter; the remainder wraps modulo 2^36
    qe     = prod_q[PROD_W-1:Q_W+1];
    qeq_d  = R_W'(qe) * R_W'(q_q);
    r0_d   = s4_q.p[R_W-1:0] - qeq_q;
    unused_bits = ^{s4_q.p[P_W-1:R_W], prod_q[Q_W:0]};
  end

  barrett_reduce_58_cond_sub u_cond_sub (
    .r0 (r0_q),
    .q  (q_q),
    .r  (r_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      s4_q        <= '0;
      pl_q        <= '0;
      ph_q        <= '0;
      prod_q      <= '0;
      qeq_q       <= '0;
      v5_q        <= 1'b0;
      tag5_q      <= '0;
      r0_q        <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_tag_q   <= '0;
    end else if (adv) begin
      s1_q        <= '{valid: bus.in_valid, p: bus.in_p, tag: bus.in_tag};
      s2_q        <= s1_q;
      pl_q        <= pl_d;
      ph_q        <= ph_d;
      s3_q        <= s2_q;
      prod_q      <= prod_d;
      s4_q        <= s3_q;
      qeq_q       <= qeq_d;
      v5_q        <= s4_q.valid;
      tag5_q      <= s4_q.tag;
      r0_q        <= r0_d;
      out_valid_q <= v5_q;
      out_r_q     <= r_d;
      out_tag_q   <= tag5_q;
    end
  end

  // Modulus reloads only when nothing is in flight so every item sees a single q/mu pair
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= '0;
      mu_q      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_we && !empty;
      if (bus.cfg_we && empty) begin
        q_q  <= bus.cfg_q;
        mu_q <= bus.cfg_mu;
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_barrett_reduce_58.sv
// Scoreboard bench for barrett_reduce_58: driver pushes expected results, monitor pops on output.
module tb_barrett_reduce_58;
  import barrett_reduce_58_pkg::*;

  localparam logic [Q_W-1:0]  Q1   = 34'h2_0000_0001;
  localparam logic [MU_W-1:0] MU1  = 36'h7_FFFF_FFFC;
  localparam logic [Q_W-1:0]  Q2   = 34'h3_FFFF_FFFF;
  localparam logic [MU_W-1:0] MU2  = 36'h4_0000_0001;
  localparam logic [Q_W-1:0]  Q3   = 34'h3_0000_0000;
  localparam logic [MU_W-1:0] MU3  = 36'h5_5555_5555;
  localparam logic [P_W-1:0]  P57  = P_W'(1) << 57;
  localparam logic [P_W-1:0]  PMAX = '1;

  typedef struct {
    logic [Q_W-1:0]   r;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  longint unsigned model_q = 0;

  always #5 clk = ~clk;

  barrett_reduce_58_if bus ();

  barrett_reduce_58 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [Q_W-1:0] model(input logic [P_W-1:0] p);
    return Q_W'(64'(p) % model_q);
  endfunction

  // Monitor: every output transfer must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else if (bus.out_valid && bus.out_ready) begin : pop_blk
      exp_t e;
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_r", 64'(bus.out_r), 64'(e.r));
        check("out_tag", 64'(bus.out_tag), 64'(e.tag));
      end
    end
  end

  task automatic send(input logic [P_W-1:0] p, input logic [TAG_W-1:0] tag,
                      input logic [Q_W-1:0] exp_r);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_p     = p;
    bus.in_tag   = tag;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready && !rst) begin
        sb.push_back('{r: exp_r, tag: tag});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) check("accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic cfg(input logic [Q_W-1:0] q, input logic [MU_W-1:0] mu, input bit expect_err);
    bus.cfg_we = 1'b1;
    bus.cfg_q  = q;
    bus.cfg_mu = mu;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    if (!expect_err) model_q = 64'(q);
    @(negedge clk);
    check("cfg_err", 64'(bus.cfg_err), 64'(expect_err));
    @(negedge clk);
    check("cfg_err_pulse", 64'(bus.cfg_err), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Load and first item in the same cycle on an empty pipeline: item must use the new modulus
  task automatic cfg_send(input logic [Q_W-1:0] q, input logic [MU_W-1:0] mu,
                          input logic [P_W-1:0] p, input logic [TAG_W-1:0] tag);
    bus.cfg_we   = 1'b1;
    bus.cfg_q    = q;
    bus.cfg_mu   = mu;
    bus.in_valid = 1'b1;
    bus.in_p     = p;
    bus.in_tag   = tag;
    model_q      = 64'(q);
    @(negedge clk);
    check("in_ready_with_cfg", 64'(bus.in_ready), 64'd1);
    if (bus.in_ready) sb.push_back('{r: model(p), tag: tag});
    @(posedge clk);
    #1;
    bus.cfg_we   = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("cfg_err_empty", 64'(bus.cfg_err), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1;
    end
    if (!done) check("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_r", 64'(bus.out_r), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_q     = '0;
    bus.cfg_mu    = '0;
    bus.in_valid  = 1'b0;
    bus.in_p      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors on q = 2^33+1
    cfg(Q1, MU1, 1'b0);
    send(P57, 8'hA5, 34'd8573157377);
    send('0, 8'h01, 34'd0);
    send(P_W'(Q1), 8'h02, 34'd0);
    send(P_W'(Q1 - 1), 8'h03, Q1 - 1);
    send(PMAX, 8'h04, 34'd8556380160);
    drain();

    // Load attempted with items in flight is dropped; load on empty pipeline takes effect
    send(P57 + 58'd12345, 8'h10, model(P57 + 58'd12345));
    send(58'd987654321987, 8'h11, model(58'd987654321987));
    send(PMAX - 58'd7, 8'h12, model(PMAX - 58'd7));
    cfg(Q2, MU2, 1'b1);
    send(58'd3_000_000_000_000, 8'h13, model(58'd3_000_000_000_000));
    send(P57, 8'h14, model(P57));
    drain();
    cfg(Q2, MU2, 1'b0);
    send(P57, 8'h20, 34'd8388608);
    send(PMAX, 8'h21, 34'd16777215);
    drain();

    // Back-to-back stream on q = 3*2^32
    cfg(Q3, MU3, 1'b0);
    send(P57, 8'h30, 34'd8589934592);
    for (int i = 0; i < 1000; i++) begin
      logic [P_W-1:0] p;
      p = P_W'({$urandom, $urandom});
      send(p, TAG_W'(i), model(p));
    end
    drain();

    // Backpressure: fill the pipe with the consumer stalled, then release
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [P_W-1:0] p;
          p = PMAX - P_W'(i * 1_000_003);
          send(p, TAG_W'(8'h40 + i), model(p));
        end
      end
      begin
        logic [Q_W-1:0]   held_r;
        logic [TAG_W-1:0] held_tag;
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
          @(negedge clk);
          if (bus.out_valid) seen = 1;
        end
        check("stall_out_valid_seen", 64'(seen), 64'd1);
        held_r   = bus.out_r;
        held_tag = bus.out_tag;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("stall_in_ready", 64'(bus.in_ready), 64'd0);
          check("stall_out_valid", 64'(bus.out_valid), 64'd1);
          check("stall_out_r_held", 64'(bus.out_r), 64'(held_r));
          check("stall_out_tag_held", 64'(bus.out_tag), 64'(held_tag));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a burst discards everything in flight
    for (int i = 0; i < 3; i++) send(P57 - P_W'(i), TAG_W'(8'h50 + i), model(P57 - P_W'(i)));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    cfg_send(Q1, MU1, P57, 8'h60);
    send(PMAX, 8'h61, 34'd8556380160);
    send(P_W'(Q1) + 58'd5, 8'h62, 34'd5);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
